// File: rtl/uart_event_packetizer.sv
// Turns game events (mole move, hit, game over) into 2-byte UART frames: header then payload.
// Define PKT_CHECKSUM_EN to append a third byte, header XOR payload, to every frame.
module uart_event_packetizer #(
  parameter logic [7:0] HDR_MOLE = 8'hA1,
  parameter logic [7:0] HDR_HIT  = 8'hA2,
  parameter logic [7:0] HDR_OVER = 8'hA3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_enable,
  input  logic [4:0] mole_position,
  input  logic       mole_hit,
  input  logic [5:0] score,
  input  logic       game_over,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       pkt_active,
  output logic [3:0] drop_count
);

  typedef enum logic [3:0] {
    IDLE, HDR, HDR_ACK, HDR_DONE, PAY, PAY_ACK, PAY_DONE
`ifdef PKT_CHECKSUM_EN
    , CHK, CHK_ACK, CHK_DONE
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  last_mole_q, last_mole_d;
  logic        hit_prev_q, hit_prev_d;
  logic        over_prev_q, over_prev_d;
  logic        armed_q, armed_d;
  logic [2:0]  pend_q, pend_d;
  logic [7:0]  mole_pay_q, mole_pay_d;
  logic [7:0]  hit_pay_q, hit_pay_d;
  logic [7:0]  over_pay_q, over_pay_d;
  logic [7:0]  frame_hdr_q, frame_hdr_d;
  logic [7:0]  frame_pay_q, frame_pay_d;
  logic [3:0]  drop_q, drop_d;

  logic        mole_evt, hit_evt, over_evt;
  logic [2:0]  clr;
  logic [1:0]  drop_inc;
  logic [4:0]  drop_sum;

  // armed_q masks the first cycle after reset so inputs already high are not seen as new events
  assign mole_evt = armed_q && game_enable && (mole_position != last_mole_q);
  assign hit_evt  = armed_q && mole_hit && !hit_prev_q;
  assign over_evt = armed_q && game_over && !over_prev_q;

  always_comb begin
    state_d     = state_q;
    frame_hdr_d = frame_hdr_q;
    frame_pay_d = frame_pay_q;
    clr         = 3'b000;
    case (state_q)
      IDLE: begin
        if ((|pend_q) && !tx_busy) begin
          state_d = HDR;
          if (pend_q[2]) begin
            frame_hdr_d = HDR_OVER;
            frame_pay_d = over_pay_q;
            clr[2]      = 1'b1;
          end else if (pend_q[1]) begin
            frame_hdr_d = HDR_HIT;
            frame_pay_d = hit_pay_q;
            clr[1]      = 1'b1;
          end else begin
            frame_hdr_d = HDR_MOLE;
            frame_pay_d = mole_pay_q;
            clr[0]      = 1'b1;
          end
        end
      end
      HDR:      state_d = HDR_ACK;
      HDR_ACK:  if (tx_busy)  state_d = HDR_DONE;
      HDR_DONE: if (!tx_busy) state_d = PAY;
      PAY:      state_d = PAY_ACK;
      PAY_ACK:  if (tx_busy)  state_d = PAY_DONE;
`ifdef PKT_CHECKSUM_EN
      PAY_DONE: if (!tx_busy) state_d = CHK;
      CHK:      state_d = CHK_ACK;
      CHK_ACK:  if (tx_busy)  state_d = CHK_DONE;
      CHK_DONE: if (!tx_busy) state_d = IDLE;
`else
      PAY_DONE: if (!tx_busy) state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // A re-arriving event overwrites its payload; it only counts as a drop if the old one was not just launched
  always_comb begin
    pend_d      = pend_q & ~clr;
    mole_pay_d  = mole_pay_q;
    hit_pay_d   = hit_pay_q;
    over_pay_d  = over_pay_q;
    last_mole_d = mole_position;
    hit_prev_d  = mole_hit;
    over_prev_d = game_over;
    armed_d     = 1'b1;
    drop_inc    = 2'd0;
    if (mole_evt) begin
      mole_pay_d = {3'b000, mole_position};
      pend_d[0]  = 1'b1;
      if (pend_q[0] && !clr[0]) drop_inc = drop_inc + 2'd1;
    end
    if (hit_evt) begin
      hit_pay_d = {2'b00, score};
      pend_d[1] = 1'b1;
      if (pend_q[1] && !clr[1]) drop_inc = drop_inc + 2'd1;
    end
    if (over_evt) begin
      over_pay_d = {2'b00, score};
      pend_d[2]  = 1'b1;
      if (pend_q[2] && !clr[2]) drop_inc = drop_inc + 2'd1;
    end
    drop_sum = {1'b0, drop_q} + {3'b000, drop_inc};
    drop_d   = (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_mole_q <= 5'd0;
      hit_prev_q  <= 1'b0;
      over_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      pend_q      <= 3'b000;
      mole_pay_q  <= 8'd0;
      hit_pay_q   <= 8'd0;
      over_pay_q  <= 8'd0;
      frame_hdr_q <= 8'd0;
      frame_pay_q <= 8'd0;
      drop_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_mole_q <= last_mole_d;
      hit_prev_q  <= hit_prev_d;
      over_prev_q <= over_prev_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      mole_pay_q  <= mole_pay_d;
      hit_pay_q   <= hit_pay_d;
      over_pay_q  <= over_pay_d;
      frame_hdr_q <= frame_hdr_d;
      frame_pay_q <= frame_pay_d;
      drop_q      <= drop_d;
    end
  end

  // The byte on tx_data stays fixed for the whole start/ack/done span of its slot
  always_comb begin
    tx_start = 1'b0;
    tx_data  = 8'd0;
    case (state_q)
      HDR: begin
        tx_start = 1'b1;
        tx_data  = frame_hdr_q;
      end
      HDR_ACK, HDR_DONE: tx_data = frame_hdr_q;
      PAY: begin
        tx_start = 1'b1;
        tx_data  = frame_pay_q;
      end
      PAY_ACK, PAY_DONE: tx_data = frame_pay_q;
`ifdef PKT_CHECKSUM_EN
      CHK: begin
        tx_start = 1'b1;
        tx_data  = frame_hdr_q ^ frame_pay_q;
      end
      CHK_ACK, CHK_DONE: tx_data = frame_hdr_q ^ frame_pay_q;
`endif
      default: begin
        tx_start = 1'b0;
        tx_data  = 8'd0;
      end
    endcase
  end

  assign pkt_active = (state_q != IDLE) || (|pend_q);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_event_packetizer.sv
// Scoreboard bench for uart_event_packetizer: stimulus pushes expected bytes, a monitor pops them on tx_start.
module tb_uart_event_packetizer;

  logic       clock;
  logic       reset;
  logic       game_enable;
  logic [4:0] mole_position;
  logic       mole_hit;
  logic [5:0] score;
  logic       game_over;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       pkt_active;
  logic [3:0] drop_count;

  logic       model_busy;
  logic       hold_busy;
  int         busy_cnt;
  int         n_checks;
  int         n_fail;
  logic [7:0] exp_q[$];

  uart_event_packetizer dut (
    .clock(clock),
    .reset(reset),
    .game_enable(game_enable),
    .mole_position(mole_position),
    .mole_hit(mole_hit),
    .score(score),
    .game_over(game_over),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .pkt_active(pkt_active),
    .drop_count(drop_count)
  );

  assign tx_busy = model_busy || hold_busy;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ge, input logic [4:0] mp, input logic mh,
                               input logic [5:0] sc, input logic go);
    @(negedge clock);
    game_enable   = ge;
    mole_position = mp;
    mole_hit      = mh;
    score         = sc;
    game_over     = go;
  endtask

  task automatic pushFrame(input logic [7:0] hdr, input logic [7:0] pay);
    exp_q.push_back(hdr);
    exp_q.push_back(pay);
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(hdr ^ pay);
`endif
  endtask

  task automatic waitIdle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !pkt_active && !tx_busy) done = 1'b1;
    end
    checkOutput("drain_within_budget", {31'd0, done}, 32'd1);
  endtask

  // Busy model: goes high one cycle after tx_start and stays high for 10 cycles
  initial begin
    model_busy = 1'b0;
    busy_cnt   = 0;
    forever begin
      @(negedge clock);
      if (busy_cnt > 0) begin
        model_busy = 1'b1;
        busy_cnt--;
      end else begin
        model_busy = 1'b0;
      end
      if (tx_start) busy_cnt = 10;
    end
  end

  initial begin
    logic [7:0] exp_byte;
    forever begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        checkOutput("tx_start_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_byte = exp_q.pop_front();
          checkOutput("tx_data_byte", {24'd0, tx_data}, {24'd0, exp_byte});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;
    n_checks      = 0;
    n_fail        = 0;
    hold_busy     = 1'b0;
    reset         = 1'b0;
    game_enable   = 1'b0;
    mole_position = 5'd0;
    mole_hit      = 1'b0;
    score         = 6'd0;
    game_over     = 1'b0;

    // Reset state, with hit/over already high across the release
    repeat (2) @(negedge clock);
    checkOutput("reset_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_pkt_active", {31'd0, pkt_active}, 32'd0);
    checkOutput("reset_drop_count", {28'd0, drop_count}, 32'd0);
    applyStimulus(1'b0, 5'd0, 1'b1, 6'd3, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("no_spurious_edge_after_reset", {31'd0, pkt_active}, 32'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 6'd0, 1'b0);

    // Mole move 00000 -> 00100, with latency check
    applyStimulus(1'b1, 5'd0, 1'b0, 6'd0, 1'b0);
    @(negedge clock);
    pushFrame(8'hA1, 8'h04);
    applyStimulus(1'b1, 5'b00100, 1'b0, 6'd0, 1'b0);
    @(negedge clock);
    checkOutput("latency_first_clock", {31'd0, tx_start}, 32'd0);
    @(negedge clock);
    checkOutput("latency_second_clock", {31'd0, tx_start}, 32'd1);
    waitIdle(200);

    // Hit and game over together: over wins arbitration
    pushFrame(8'hA3, 8'h0C);
    pushFrame(8'hA2, 8'h0C);
    applyStimulus(1'b1, 5'b00100, 1'b1, 6'd12, 1'b1);
    waitIdle(300);
    checkOutput("simultaneous_drop_count", {28'd0, drop_count}, 32'd0);
    applyStimulus(1'b1, 5'b00100, 1'b0, 6'd12, 1'b0);

    // Three mole moves while blocked: last one wins, two drops
    @(negedge clock);
    hold_busy = 1'b1;
    applyStimulus(1'b1, 5'b00001, 1'b0, 6'd12, 1'b0);
    applyStimulus(1'b1, 5'b00010, 1'b0, 6'd12, 1'b0);
    applyStimulus(1'b1, 5'b01000, 1'b0, 6'd12, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("blocked_drop_count", {28'd0, drop_count}, 32'd2);
    checkOutput("blocked_pkt_active", {31'd0, pkt_active}, 32'd1);
    pushFrame(8'hA1, 8'h08);
    hold_busy = 1'b0;
    waitIdle(200);
    checkOutput("after_release_drop_count", {28'd0, drop_count}, 32'd2);

    // 18 overwrites while blocked: drop_count saturates
    @(negedge clock);
    hold_busy = 1'b1;
    for (int i = 0; i < 18; i++)
      applyStimulus(1'b1, (i % 2 == 1) ? 5'b00010 : 5'b00001, 1'b0, 6'd12, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("saturated_drop_count", {28'd0, drop_count}, 32'd15);
    pushFrame(8'hA1, 8'h02);
    hold_busy = 1'b0;
    waitIdle(200);
    checkOutput("saturated_drop_hold", {28'd0, drop_count}, 32'd15);

    // Reset during HDR_DONE abandons the frame
    applyStimulus(1'b1, 5'b00010, 1'b0, 6'd5, 1'b0);
    exp_q.push_back(8'hA2);
    applyStimulus(1'b1, 5'b00010, 1'b1, 6'd5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) seen = 1'b1;
    end
    checkOutput("header_before_reset_sent", {31'd0, seen}, 32'd1);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midframe_reset_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("midframe_reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("midframe_reset_pkt_active", {31'd0, pkt_active}, 32'd0);
    checkOutput("midframe_reset_drop_count", {28'd0, drop_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("post_reset_quiet", {31'd0, pkt_active}, 32'd0);
    pushFrame(8'hA2, 8'h09);
    applyStimulus(1'b1, 5'b00010, 1'b0, 6'd9, 1'b0);
    applyStimulus(1'b1, 5'b00010, 1'b1, 6'd9, 1'b0);
    waitIdle(200);

    // Mole changes with game disabled, then enable with a stable mole
    applyStimulus(1'b0, 5'b00001, 1'b0, 6'd9, 1'b0);
    applyStimulus(1'b0, 5'b00100, 1'b0, 6'd9, 1'b0);
    applyStimulus(1'b0, 5'b10000, 1'b0, 6'd9, 1'b0);
    repeat (10) @(negedge clock);
    checkOutput("disabled_no_frame", {31'd0, pkt_active}, 32'd0);
    applyStimulus(1'b1, 5'b10000, 1'b0, 6'd9, 1'b0);
    repeat (10) @(negedge clock);
    checkOutput("enable_stable_no_frame", {31'd0, pkt_active}, 32'd0);
    checkOutput("final_drop_count", {28'd0, drop_count}, 32'd0);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
